// File: rtl/camera_ctrl_pkg.sv
// Shared types and constants for the pixel-array capture sequencer.
// Readout steps, state encoding and the strobe decode used by camera_ctrl.
package camera_pkg;

  localparam int EXP_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPOSE  = 2'd1,
    READOUT = 2'd2
  } state_e;

  localparam logic [2:0] RD_NRE1 = 3'd0;
  localparam logic [2:0] RD_ADC1 = 3'd1;
  localparam logic [2:0] RD_GAP  = 3'd2;
  localparam logic [2:0] RD_NRE2 = 3'd3;
  localparam logic [2:0] RD_ADC2 = 3'd4;
  localparam logic [2:0] RD_END  = 3'd5;

  typedef struct packed {
    logic erase;
    logic expose;
    logic nre_1;
    logic nre_2;
    logic adc;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '{erase: 1'b1, expose: 1'b0, nre_1: 1'b1,
                                        nre_2: 1'b1, adc: 1'b0};

  // Array pin levels for a given state/step; nre lines are active low.
  function automatic strobes_t decode_strobes(state_e st, logic [2:0] step);
    strobes_t s;
    s = '{erase: 1'b0, expose: 1'b0, nre_1: 1'b1, nre_2: 1'b1, adc: 1'b0};
    case (st)
      IDLE:    s = STROBES_IDLE;
      EXPOSE:  s.expose = 1'b1;
      READOUT: begin
        case (step)
          RD_NRE1: s.nre_1 = 1'b0;
          RD_ADC1: begin
            s.nre_1 = 1'b0;
            s.adc   = 1'b1;
          end
          RD_NRE2: s.nre_2 = 1'b0;
          RD_ADC2: begin
            s.nre_2 = 1'b0;
            s.adc   = 1'b1;
          end
          default: s.adc = 1'b0;
        endcase
      end
      default: s = STROBES_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/camera_ctrl_if.sv
// Button inputs, array/ADC control pins and FSM debug view of camera_ctrl.
// Plain level signals: there is no valid/ready handshake on this bus.
interface camera_ctrl_if import camera_pkg::*; ();

  logic                 init;
  logic                 exp_increase;
  logic                 exp_decrease;
  logic                 erase;
  logic                 expose;
  logic                 nre_1;
  logic                 nre_2;
  logic                 adc;
  logic [EXP_WIDTH-1:0] exp_time;
  state_e               state_dbg;
  logic [2:0]           step_dbg;

  modport master (
    output init, exp_increase, exp_decrease,
    input  erase, expose, nre_1, nre_2, adc, exp_time, state_dbg, step_dbg
  );

  modport slave (
    input  init, exp_increase, exp_decrease,
    output erase, expose, nre_1, nre_2, adc, exp_time, state_dbg, step_dbg
  );

endinterface

// File: rtl/camera_ctrl_timer.sv
// Exposure countdown: loadable down-counter that saturates at zero.
// done flags the last exposure cycle (count of 1 or below).
module exposure_timer import camera_pkg::*; (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 enable,
  input  logic [EXP_WIDTH-1:0] load_value,
  output logic                 done
);

  logic [EXP_WIDTH-1:0] count_q;
  logic [EXP_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q <= EXP_WIDTH'(1));

endmodule

// File: rtl/camera_ctrl.sv
// Capture sequencer: erase (idle) -> expose for exp_time cycles -> two-row
// readout. All array pins are registered; exp_time is adjustable only in IDLE.
module camera_ctrl import camera_pkg::*; #(
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_DEFAULT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  camera_ctrl_if.slave  bus
);

  localparam logic [EXP_WIDTH-1:0] EXP_MIN_V     = EXP_MIN[EXP_WIDTH-1:0];
  localparam logic [EXP_WIDTH-1:0] EXP_MAX_V     = EXP_MAX[EXP_WIDTH-1:0];
  localparam logic [EXP_WIDTH-1:0] EXP_DEFAULT_V = EXP_DEFAULT[EXP_WIDTH-1:0];

  state_e               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic [EXP_WIDTH-1:0] exp_time_q, exp_time_d;
  strobes_t             strobes_q;
  logic                 timer_load;
  logic                 timer_enable;
  logic                 timer_done;

  exposure_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .enable     (timer_enable),
    .load_value (exp_time_q),
    .done       (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    exp_time_d   = exp_time_q;
    timer_load   = 1'b0;
    timer_enable = (state_q == EXPOSE);
    case (state_q)
      IDLE: begin
        // init wins over the adjust buttons in the same cycle.
        if (bus.init) begin
          timer_load = 1'b1;
          state_d    = EXPOSE;
        end else if (bus.exp_increase && !bus.exp_decrease) begin
          if (exp_time_q < EXP_MAX_V) exp_time_d = exp_time_q + 1'b1;
        end else if (bus.exp_decrease && !bus.exp_increase) begin
          if (exp_time_q > EXP_MIN_V) exp_time_d = exp_time_q - 1'b1;
        end
      end
      EXPOSE: begin
        if (timer_done) begin
          state_d = READOUT;
          step_d  = RD_NRE1;
        end
      end
      READOUT: begin
        if (step_q == RD_END) begin
          state_d = IDLE;
          step_d  = RD_NRE1;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = RD_NRE1;
      end
    endcase
  end

  // Strobes are registered from the next state so pins line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      step_q     <= RD_NRE1;
      exp_time_q <= EXP_DEFAULT_V;
      strobes_q  <= STROBES_IDLE;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      exp_time_q <= exp_time_d;
      strobes_q  <= decode_strobes(state_d, step_d);
    end
  end

  assign bus.erase     = strobes_q.erase;
  assign bus.expose    = strobes_q.expose;
  assign bus.nre_1     = strobes_q.nre_1;
  assign bus.nre_2     = strobes_q.nre_2;
  assign bus.adc       = strobes_q.adc;
  assign bus.exp_time  = exp_time_q;
  assign bus.state_dbg = state_q;
  assign bus.step_dbg  = step_q;

endmodule

// File: tb/tb_camera_ctrl.sv
// Bench for camera_ctrl: capture timeline model indexed by cycles since init,
// compared every cycle against the pins and exp_time.
module tb_camera_ctrl;
  import camera_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  camera_ctrl_if cif ();

  camera_ctrl #(.EXP_MIN(2), .EXP_MAX(30), .EXP_DEFAULT(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (cif.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_off: cycles since the init edge (0 = idle), m_e: exposure latched at init.
  int m_exp;
  int m_off;
  int m_e;
  logic [9:0] exp_q[$];

  localparam logic [9:0] RESET_VEC = {5'b10110, 5'd16};

  function automatic logic [9:0] model_out();
    logic [4:0] s;
    logic [4:0] e;
    int r;
    s = 5'b10110;
    if (m_off == 0) s = 5'b10110;
    else if (m_off <= m_e) s = 5'b01110;
    else begin
      r = m_off - m_e;
      case (r)
        1:       s = 5'b00010;
        2:       s = 5'b00011;
        3:       s = 5'b00110;
        4:       s = 5'b00100;
        5:       s = 5'b00101;
        default: s = 5'b00110;
      endcase
    end
    e = m_exp[4:0];
    return {s, e};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {cif.erase, cif.expose, cif.nre_1, cif.nre_2, cif.adc, cif.exp_time};
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      m_exp = 16;
      m_off = 0;
    end else if (m_off == 0) begin
      if (cif.init) begin
        m_e   = m_exp;
        m_off = 1;
      end else if (cif.exp_increase && !cif.exp_decrease) begin
        m_exp = (m_exp < 30) ? m_exp + 1 : 30;
      end else if (cif.exp_decrease && !cif.exp_increase) begin
        m_exp = (m_exp > 2) ? m_exp - 1 : 2;
      end
    end else begin
      m_off++;
      if (m_off > m_e + 6) m_off = 0;
    end
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic set_inputs(logic i, logic inc, logic dec);
    cif.init         = i;
    cif.exp_increase = inc;
    cif.exp_decrease = dec;
  endtask

  task automatic set_exp(int v);
    for (int n = 0; n < 40 && m_exp != v; n++) begin
      if (m_exp < v) set_inputs(1'b0, 1'b1, 1'b0);
      else set_inputs(1'b0, 1'b0, 1'b1);
      tick();
    end
    set_inputs(1'b0, 1'b0, 1'b0);
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [9:0] got;
    got = dut_vec();
    checks++;
    if (got !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_pins got %b want %b", got, RESET_VEC);
    end
    checks++;
    if (cif.state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d want %0d", cif.state_dbg, IDLE);
    end
  endtask

  task automatic test_default_capture();
    logic [9:0] got, want;
    int n_expose;
    n_expose = 0;
    set_exp(16);
    set_inputs(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      tick();
      set_inputs(1'b0, 1'b0, 1'b0);
      got  = dut_vec();
      want = exp_q.pop_front();
      if (cif.expose === 1'b1) n_expose++;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL default_capture cyc %0d got %b want %b", c, got, want);
      end
    end
    checks++;
    if (n_expose != 16) begin
      errors++;
      $display("FAIL default_expose_len got %0d want 16", n_expose);
    end
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL default_back_idle got %b want %b", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_saturation();
    logic [9:0] got, want;
    int n_expose;
    set_exp(29);
    for (int c = 0; c < 3; c++) begin
      set_inputs(1'b0, 1'b1, 1'b0);
      tick();
      got  = dut_vec();
      want = exp_q.pop_front();
      checks++;
      if (got !== want || cif.exp_time !== 5'd30) begin
        errors++;
        $display("FAIL sat_max step %0d got %b want %b", c, got, want);
      end
    end
    set_exp(3);
    for (int c = 0; c < 3; c++) begin
      set_inputs(1'b0, 1'b0, 1'b1);
      tick();
      got  = dut_vec();
      want = exp_q.pop_front();
      checks++;
      if (got !== want || cif.exp_time !== 5'd2) begin
        errors++;
        $display("FAIL sat_min step %0d got %b want %b", c, got, want);
      end
    end
    n_expose = 0;
    set_inputs(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      set_inputs(1'b0, 1'b0, 1'b0);
      got  = dut_vec();
      want = exp_q.pop_front();
      if (cif.expose === 1'b1) n_expose++;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL min_capture cyc %0d got %b want %b", c, got, want);
      end
    end
    checks++;
    if (n_expose != 2) begin
      errors++;
      $display("FAIL min_expose_len got %0d want 2", n_expose);
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] got, want;
    set_exp(10);
    set_inputs(1'b0, 1'b1, 1'b1);
    tick();
    got  = dut_vec();
    want = exp_q.pop_front();
    checks++;
    if (got !== want || cif.exp_time !== 5'd10) begin
      errors++;
      $display("FAIL inc_dec_both got %b want %b", got, want);
    end
    set_inputs(1'b1, 1'b1, 1'b0);
    tick();
    got  = dut_vec();
    want = exp_q.pop_front();
    checks++;
    if (got !== want || cif.expose !== 1'b1 || cif.exp_time !== 5'd10) begin
      errors++;
      $display("FAIL init_with_inc got %b want %b", got, want);
    end
    set_inputs(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 15; c++) begin
      tick();
      got  = dut_vec();
      want = exp_q.pop_front();
      checks++;
      if (got !== want || cif.exp_time !== 5'd10) begin
        errors++;
        $display("FAIL inc_while_busy cyc %0d got %b want %b", c, got, want);
      end
    end
    set_inputs(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    exp_q.delete();
  endtask

  task automatic test_init_held();
    logic [9:0] got, want;
    int last_rise;
    int rises;
    logic prev_expose;
    set_exp(5);
    last_rise   = -1;
    rises       = 0;
    prev_expose = 1'b0;
    set_inputs(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      tick();
      got  = dut_vec();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL init_held cyc %0d got %b want %b", c, got, want);
      end
      checks++;
      if ((cif.nre_1 === 1'b0 && cif.nre_2 === 1'b0) ||
          (cif.adc === 1'b1 && !((cif.nre_1 ^ cif.nre_2) === 1'b1))) begin
        errors++;
        $display("FAIL strobe_exclusive cyc %0d got nre1 %b nre2 %b adc %b want exactly one nre low with adc",
                 c, cif.nre_1, cif.nre_2, cif.adc);
      end
      if (cif.expose === 1'b1 && !prev_expose) begin
        if (last_rise >= 0) begin
          checks++;
          if (c - last_rise != 12) begin
            errors++;
            $display("FAIL restart_period got %0d want 12", c - last_rise);
          end
        end
        last_rise = c;
        rises++;
      end
      prev_expose = cif.expose;
    end
    checks++;
    if (rises != 9) begin
      errors++;
      $display("FAIL restart_count got %0d want 9", rises);
    end
    set_inputs(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 14; c++) tick();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [9:0] got, want;
    for (int c = 0; c < 400; c++) begin
      set_inputs($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
      tick();
      got  = dut_vec();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", c, got, want);
      end
    end
    set_inputs(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) tick();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_expose();
    logic [9:0] got, want;
    set_exp(20);
    set_inputs(1'b1, 1'b0, 1'b0);
    tick();
    set_inputs(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1;
    got = dut_vec();
    checks++;
    if (got !== RESET_VEC || cif.state_dbg !== IDLE) begin
      errors++;
      $display("FAIL async_reset got %b want %b", got, RESET_VEC);
    end
    m_exp = 16;
    m_off = 0;
    tick();
    reset_n = 1'b1;
    want = exp_q.pop_front();
    got  = dut_vec();
    checks++;
    if (got !== RESET_VEC || want !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_held got %b want %b", got, RESET_VEC);
    end
    tick();
    got  = dut_vec();
    want = exp_q.pop_front();
    checks++;
    if (got !== want || cif.state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_release got %b want %b", got, want);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    m_exp   = 16;
    m_off   = 0;
    m_e     = 0;
    reset_n = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_default_capture();
    test_saturation();
    test_simultaneous();
    test_init_held();
    test_random();
    test_reset_mid_expose();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
